// File: rtl/stage_pkg.sv
// Shared decode encodings for the ID stage: opcodes, op/operand types, and the
// packed control bundle carried through ID/EX.
package stage_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;

    typedef enum logic [2:0] {
        OPT_NONE, OPT_ALU_R, OPT_ALU_I, OPT_LOAD,
        OPT_STORE, OPT_BRANCH, OPT_JUMP, OPT_UPPER
    } op_type_e;

    typedef enum logic [1:0] {OPD1_NONE, OPD1_RS1, OPD1_PC, OPD1_ZERO} opd1_e;
    typedef enum logic [1:0] {OPD2_NONE, OPD2_RS2, OPD2_IMM, OPD2_FOUR} opd2_e;

    typedef struct packed {
        op_type_e op_type;
        opd1_e    operand1_type;
        opd2_e    operand2_type;
        logic     is_jalr;
        logic     is_br;
        logic     mem_read_ena;
        logic     mem_write_ena;
        logic     reg_write_ena;
        logic     mem2reg;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{OPT_NONE, OPD1_NONE, OPD2_NONE,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/ctrl.sv
// Opcode to control-bundle decoder; unknown opcodes decode to a bubble.
module ctrl
    import stage_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      dec
);
    always_comb begin
        dec = BUBBLE;
        case (opcode)
            OP_LUI:   dec = '{OPT_UPPER,  OPD1_ZERO, OPD2_IMM,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_AUIPC: dec = '{OPT_UPPER,  OPD1_PC,   OPD2_IMM,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_JAL:   dec = '{OPT_JUMP,   OPD1_PC,   OPD2_FOUR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_JALR:  dec = '{OPT_JUMP,   OPD1_PC,   OPD2_FOUR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_BR:    dec = '{OPT_BRANCH, OPD1_RS1,  OPD2_RS2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            OP_LOAD:  dec = '{OPT_LOAD,   OPD1_RS1,  OPD2_IMM,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            OP_STORE: dec = '{OPT_STORE,  OPD1_RS1,  OPD2_IMM,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            OP_IMM:   dec = '{OPT_ALU_I,  OPD1_RS1,  OPD2_IMM,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_R:     dec = '{OPT_ALU_R,  OPD1_RS1,  OPD2_RS2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            default:  dec = BUBBLE;
        endcase
    end
endmodule

// File: rtl/imm_gen.sv
// Immediate extraction for I/S/B/U/J formats, sign-extended to XLEN.
module imm_gen
    import stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);
    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BR:           imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {inst[31:12], 12'b0};
            OP_JAL:          imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:         imm32 = '0;
        endcase
    end

    // Signed source makes the size cast sign-extend when XLEN > 32.
    assign imm = XLEN'(imm32);
endmodule

// File: rtl/stage_id_pipe_reg_file_bp.sv
// NREG x XLEN register file, two combinational read ports, one write port,
// optional write-first bypass of the same-cycle WB write.
module reg_file_bp
    import stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    localparam int REG_AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_hit;

    assign wr_hit = we && (waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            regs[waddr[REG_AW-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1[REG_AW-1:0]];
        if (raddr1[REG_AW-1:0] == '0)
            rdata1 = '0;
        else if (BYPASS != 0 && wr_hit && waddr == raddr1)
            rdata1 = wdata;
    end

    always_comb begin
        rdata2 = regs[raddr2[REG_AW-1:0]];
        if (raddr2[REG_AW-1:0] == '0)
            rdata2 = '0;
        else if (BYPASS != 0 && wr_hit && waddr == raddr2)
            rdata2 = wdata;
    end
endmodule

// File: rtl/stage_id_pipe.sv
// Decode stage with register read, load-use hazard detection and a registered
// ID/EX pipeline register supporting bubble, flush and hold.
module stage_id_pipe
    import stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            wb_reg_write_ena,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_func3,
    output logic [6:0]      ex_func7,
    output logic [2:0]      ex_op_type,
    output logic [1:0]      ex_operand1_type,
    output logic [1:0]      ex_operand2_type,
    output logic            ex_is_jalr,
    output logic            ex_is_br,
    output logic            ex_mem_read_ena,
    output logic            ex_mem_write_ena,
    output logic            ex_reg_write_ena,
    output logic            ex_mem2reg
);
    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    ctrl_t           dec_ctrl, ex_ctrl;
    logic [XLEN-1:0] dec_imm, rs1_data, rs2_data;
    logic            uses_rs1, uses_rs2, hazard, load_bubble;

    assign opcode = if_inst[6:0];
    assign rs1    = if_inst[19:15];
    assign rs2    = if_inst[24:20];
    assign rd     = if_inst[11:7];

    ctrl u_ctrl (.opcode(opcode), .dec(dec_ctrl));

    imm_gen #(.XLEN(XLEN)) u_imm_gen (.inst(if_inst), .imm(dec_imm));

    reg_file_bp #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_reg_file (
        .clk(clk), .reset(reset),
        .we(wb_reg_write_ena), .waddr(wb_rd), .wdata(wb_data),
        .raddr1(rs1), .raddr2(rs2),
        .rdata1(rs1_data), .rdata2(rs2_data)
    );

    assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign uses_rs2 = (opcode == OP_R || opcode == OP_STORE || opcode == OP_BR);

    assign hazard = if_valid && ex_valid && ex_ctrl.mem_read_ena && (ex_rd != 5'd0) &&
                    ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));

    assign id_stall = !flush && (ex_hold || hazard);

    // Flush outranks hold, hold outranks the hazard/idle bubble.
    assign load_bubble = flush || (!ex_hold && (hazard || !if_valid));

    always_ff @(posedge clk) begin
        if (reset || load_bubble) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= BUBBLE;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_func3    <= '0;
            ex_func7    <= '0;
        end else if (!ex_hold) begin
            ex_valid    <= 1'b1;
            ex_ctrl     <= dec_ctrl;
            ex_pc       <= if_pc;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_imm      <= dec_imm;
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_rd       <= rd;
            ex_func3    <= if_inst[14:12];
            ex_func7    <= if_inst[31:25];
        end
    end

    assign ex_op_type       = ex_ctrl.op_type;
    assign ex_operand1_type = ex_ctrl.operand1_type;
    assign ex_operand2_type = ex_ctrl.operand2_type;
    assign ex_is_jalr       = ex_ctrl.is_jalr;
    assign ex_is_br         = ex_ctrl.is_br;
    assign ex_mem_read_ena  = ex_ctrl.mem_read_ena;
    assign ex_mem_write_ena = ex_ctrl.mem_write_ena;
    assign ex_reg_write_ena = ex_ctrl.reg_write_ena;
    assign ex_mem2reg       = ex_ctrl.mem2reg;
endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed bench for stage_id_pipe: a table-driven reference model of the ID/EX
// contents checked every cycle, plus hand-computed literal expectations.
module tb_stage_id_pipe;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int BP   = 1;

    logic            clk = 1'b0;
    logic            reset, if_valid, wb_reg_write_ena, flush, ex_hold;
    logic [31:0]     if_inst;
    logic [XLEN-1:0] if_pc, wb_data;
    logic [4:0]      wb_rd;
    logic            id_stall, ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_func3, ex_op_type;
    logic [6:0]      ex_func7;
    logic [1:0]      ex_operand1_type, ex_operand2_type;
    logic            ex_is_jalr, ex_is_br, ex_mem_read_ena, ex_mem_write_ena;
    logic            ex_reg_write_ena, ex_mem2reg;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    stage_id_pipe #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BP)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .wb_reg_write_ena(wb_reg_write_ena), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_func3(ex_func3), .ex_func7(ex_func7),
        .ex_op_type(ex_op_type), .ex_operand1_type(ex_operand1_type),
        .ex_operand2_type(ex_operand2_type), .ex_is_jalr(ex_is_jalr), .ex_is_br(ex_is_br),
        .ex_mem_read_ena(ex_mem_read_ena), .ex_mem_write_ena(ex_mem_write_ena),
        .ex_reg_write_ena(ex_reg_write_ena), .ex_mem2reg(ex_mem2reg)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [12:0] ctl;   // {op_type, opd1, opd2, jalr, br, mrd, mwr, rwr, m2r}
    } exp_t;

    exp_t        m;
    logic [31:0] mregs [32];

    function automatic logic [12:0] ctl_of(input logic [6:0] op);
        case (op)
            7'h37:   return {3'd7, 2'd3, 2'd2, 6'b000010};
            7'h17:   return {3'd7, 2'd2, 2'd2, 6'b000010};
            7'h6F:   return {3'd6, 2'd2, 2'd3, 6'b000010};
            7'h67:   return {3'd6, 2'd2, 2'd3, 6'b100010};
            7'h63:   return {3'd5, 2'd1, 2'd1, 6'b010000};
            7'h03:   return {3'd3, 2'd1, 2'd2, 6'b001011};
            7'h23:   return {3'd4, 2'd1, 2'd2, 6'b000100};
            7'h13:   return {3'd2, 2'd1, 2'd2, 6'b000010};
            7'h33:   return {3'd1, 2'd1, 2'd1, 6'b000010};
            default: return 13'd0;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67: return {{20{i[31]}}, i[31:20]};
            7'h23:   return {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'h37, 7'h17: return {i[31:12], 12'b0};
            7'h6F:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rd_val(input logic [4:0] a);
        if ((a % NREG) == 0) return 32'd0;
        if (BP != 0 && wb_reg_write_ena && wb_rd != 0 && wb_rd == a) return wb_data;
        return mregs[a % NREG];
    endfunction

    function automatic logic m_hazard();
        logic [6:0] op;
        logic       u1, u2;
        op = if_inst[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return if_valid && m.valid && m.ctl[3] && m.rd != 0 &&
               ((u1 && if_inst[19:15] == m.rd) || (u2 && if_inst[24:20] == m.rd));
    endfunction

    always @(posedge clk) begin
        exp_t nxt;
        nxt = m;
        if (reset) begin
            nxt = '0;
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else begin
            if (flush || (!ex_hold && (m_hazard() || !if_valid))) begin
                nxt = '0;
            end else if (!ex_hold) begin
                nxt.valid = 1'b1;
                nxt.pc    = if_pc;
                nxt.d1    = rd_val(if_inst[19:15]);
                nxt.d2    = rd_val(if_inst[24:20]);
                nxt.imm   = imm_of(if_inst);
                nxt.rs1   = if_inst[19:15];
                nxt.rs2   = if_inst[24:20];
                nxt.rd    = if_inst[11:7];
                nxt.f3    = if_inst[14:12];
                nxt.f7    = if_inst[31:25];
                nxt.ctl   = ctl_of(if_inst[6:0]);
            end
            if (wb_reg_write_ena && wb_rd != 0) mregs[wb_rd % NREG] = wb_data;
        end
        m = nxt;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("id_stall", id_stall, !flush && (ex_hold || m_hazard()));
            chk("ex_valid", ex_valid, m.valid);
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_rs1_data", ex_rs1_data, m.d1);
            chk("ex_rs2_data", ex_rs2_data, m.d2);
            chk("ex_imm", ex_imm, m.imm);
            chk("ex_idx", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
            chk("ex_func", {ex_func3, ex_func7}, {m.f3, m.f7});
            chk("ex_ctl", {ex_op_type, ex_operand1_type, ex_operand2_type, ex_is_jalr, ex_is_br,
                           ex_mem_read_ena, ex_mem_write_ena, ex_reg_write_ena, ex_mem2reg}, m.ctl);
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
    localparam logic [31:0] LW_X2      = 32'h0000A103;
    localparam logic [31:0] ADD_X3_X2  = 32'h002101B3;
    localparam logic [31:0] LUI_X2     = 32'h00001137;
    localparam logic [31:0] ADD_X3_X0  = 32'h000001B3;
    localparam logic [31:0] ADDI_X6_X5 = 32'h00028313;
    localparam logic [31:0] ADDI_X7_X0 = 32'h00000393;
    localparam logic [31:0] ADDI_X8_X4 = 32'h00020413;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    initial begin
        logic [31:0] misc [5];
        misc[0] = 32'h0020A423;   // sw   x2,8(x1)
        misc[1] = 32'hFE208EE3;   // beq  x1,x2,-4
        misc[2] = 32'h008000EF;   // jal  x1,8
        misc[3] = 32'h12345297;   // auipc x5,0x12345
        misc[4] = 32'h00008067;   // jalr x0,0(x1)

        reset = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0;
        wb_reg_write_ena = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_hold = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("reset_ex_valid", ex_valid, 0);
        chk("reset_id_stall", id_stall, 0);
        chk("reset_ex_rd", ex_rd, 0);
        reset = 1'b0;

        issue(ADDI_X1_5, 32'h100);
        tick();
        chk("addi_valid", ex_valid, 1);
        chk("addi_rd", ex_rd, 1);
        chk("addi_imm", ex_imm, 5);
        chk("addi_rwe", ex_reg_write_ena, 1);
        chk("addi_rs1_data", ex_rs1_data, 0);
        chk("addi_pc", ex_pc, 32'h100);

        // load-use: exactly one bubble, then the add issues
        issue(LW_X2, 32'h104);
        tick();
        issue(ADD_X3_X2, 32'h108);
        #1 chk("lu_stall", id_stall, 1);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_stall_clear", id_stall, 0);
        tick();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rs", {ex_rs1, ex_rs2, ex_rd}, {5'd2, 5'd2, 5'd3});

        // no false stall
        issue(LW_X2, 32'h10C);
        tick();
        issue(LUI_X2, 32'h110);
        #1 chk("nofs_lui", id_stall, 0);
        tick();
        chk("lui_imm", ex_imm, 32'h1000);
        issue(LW_X2, 32'h114);
        tick();
        issue(ADD_X3_X0, 32'h118);
        #1 chk("nofs_add", id_stall, 0);
        tick();

        // bypass of a same-cycle WB write, and WB to x0 ignored
        if_valid = 1'b0;
        wb_reg_write_ena = 1'b1; wb_rd = 5'd5; wb_data = 32'h11111111;
        tick();
        issue(ADDI_X6_X5, 32'h11C);
        wb_data = 32'hDEADBEEF;
        tick();
        chk("bypass_rs1", ex_rs1_data, (BP != 0) ? 32'hDEADBEEF : 32'h11111111);
        issue(ADDI_X7_X0, 32'h120);
        wb_rd = 5'd0; wb_data = 32'h12345678;
        tick();
        chk("x0_read", ex_rs1_data, 0);
        wb_reg_write_ena = 1'b0;

        // flush together with a hazard
        issue(LW_X2, 32'h124);
        tick();
        issue(ADD_X3_X2, 32'h128);
        flush = 1'b1;
        #1 chk("flush_stall", id_stall, 0);
        tick();
        flush = 1'b0;
        chk("flush_bubble", {ex_valid, ex_mem_read_ena, ex_reg_write_ena, ex_op_type}, 0);

        // hold for three cycles with a WB write in the middle
        issue(ADDI_X1_5, 32'h12C);
        tick();
        issue(ADDI_X8_X4, 32'h130);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_reg_write_ena = (i == 1); wb_rd = 5'd4; wb_data = 32'h0000ABCD;
            #1 chk("hold_stall", id_stall, 1);
            tick();
            chk("hold_stable", {ex_valid, ex_rd, ex_imm, ex_pc}, {1'b1, 5'd1, 32'd5, 32'h12C});
        end
        wb_reg_write_ena = 1'b0;
        ex_hold = 1'b0;
        tick();
        chk("release_rs1", ex_rs1_data, 32'h0000ABCD);
        chk("release_rd", ex_rd, 8);

        // reset while stalled
        issue(LW_X2, 32'h134);
        tick();
        issue(ADD_X3_X2, 32'h138);
        reset = 1'b1;
        #1 chk("pre_reset_stall", id_stall, 1);
        tick();
        reset = 1'b0;
        chk("rst_stall_valid", ex_valid, 0);
        chk("rst_stall_drop", id_stall, 0);
        issue(ADDI_X6_X5, 32'h13C);
        tick();
        chk("rst_regs_clear", ex_rs1_data, 0);

        // remaining formats
        for (int i = 0; i < 5; i++) begin
            issue(misc[i], 32'h200 + 32'(i * 4));
            tick();
            if (i == 1) chk("beq_imm", ex_imm, 32'hFFFFFFFC);
            if (i == 2) chk("jal_imm", ex_imm, 32'd8);
            if (i == 3) chk("auipc_imm", ex_imm, 32'h12345000);
        end
        if_valid = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
- Parametrised successor to the combinational decode stage.
- Decodes the instruction held in IF/ID and reads the register file, with an optional write-first bypass from WB.
- Detects load-use hazards and registers all decode results into an internal ID/EX pipeline register, with bubble, flush and hold control.
- Sits between the IF/ID register and the execute stage; all ex_* outputs are registered.

Parameters:
- XLEN, 32, datapath width (rs data, imm, pc).
- NREG, 32, number of architectural registers (32 = RV32I, 16 = RV32E); REG_AW = clog2(NREG).
- BYPASS, 1, 1 = same-cycle WB write is visible on the ID read; 0 = the ID read returns the old value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_valid  in  1  IF/ID holds a valid instruction
- if_inst  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- wb_reg_write_ena  in  1  WB write enable
- wb_rd  in  5  WB destination index
- wb_data  in  XLEN  WB write data
- flush  in  1  taken branch/jump; kill the instruction currently in ID
- ex_hold  in  1  EX cannot accept; freeze ID/EX
- id_stall  out  1  IF and IF/ID must hold their contents this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered data
- ex_rs1, ex_rs2, ex_rd  out  5  registered register indices
- ex_func3 out 3; ex_func7 out 7
- ex_op_type out 3; ex_operand1_type out 2; ex_operand2_type out 2
- ex_is_jalr, ex_is_br, ex_mem_read_ena, ex_mem_write_ena, ex_reg_write_ena, ex_mem2reg  out  1 each

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- On reset: every ex_* output is 0, ex_valid is 0, and all NREG registers are 0. id_stall is combinational and evaluates to 0 while ex_valid is 0.
- Latency: an instruction accepted at edge N appears on ex_* after edge N. Throughput is one instruction per cycle when there is no hazard.
- Decode: control fields use the existing ctrl/imm_gen encodings. Field slicing: rs1 = [19:15], rs2 = [24:20], rd = [11:7], func3 = [14:12], func7 = [31:25].
- Register file write: on the clk edge when wb_reg_write_ena = 1 and wb_rd != 0. Index is wb_rd[REG_AW-1:0].
- Register file read: combinational. x0 always reads 0.
  - BYPASS = 1: if wb_reg_write_ena = 1, wb_rd != 0 and wb_rd == rsN, the read returns wb_data.
- uses_rs1: opcode is not LUI, AUIPC or JAL.
- uses_rs2: opcode is R-type, STORE or BRANCH.
- hazard = if_valid & ex_valid & ex_mem_read_ena & (ex_rd != 0) & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd)).
- id_stall = !flush & (ex_hold | hazard).
- ID/EX update priority, evaluated every edge:
  1. reset: clear everything.
  2. flush: load a bubble.
  3. ex_hold: keep all ID/EX contents unchanged.
  4. hazard or !if_valid: load a bubble.
  5. Otherwise: load the decoded instruction with ex_valid = 1.
- Bubble: ex_valid and all control outputs (op_type, operand types, is_jalr, is_br, mem_read/write, reg_write, mem2reg) are 0. Data and index fields are also 0.
- Hazard resolution: a load-use hazard inserts exactly one bubble. The next cycle ex_mem_read_ena = 0, so the held instruction proceeds.
- Simultaneous events:
  - flush together with hazard: flush wins and id_stall = 0.
  - WB write to x0: ignored.
  - A WB write during ex_hold still updates the register file.
  - reset asserted mid-stall: ID/EX is cleared and id_stall drops in the same cycle.
- Reads during hold: while held, rs data is re-read each cycle, but ID/EX does not capture it until released. When released, the current (possibly WB-updated) value is latched.

Decomposition:
- Package stage_pkg holds:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_R);
  - op_type and operand-type encodings;
  - a BUBBLE control constant.
- Sub-module reg_file_bp: NREG x XLEN storage, two read ports and one write port, with the BYPASS parameter.
- ctrl and imm_gen are instantiated unchanged; ID/EX register and hazard logic live in the top module.

Test Plan:
- Reset, then if_valid = 1 with addi x1,x0,5 (0x00500093) -> next cycle ex_valid = 1, ex_rd = 1, ex_imm = 5, ex_reg_write_ena = 1, ex_rs1_data = 0.
- Load-use: lw x2,0(x1) then add x3,x2,x2 -> id_stall = 1 for one cycle, one bubble (ex_valid = 0), then the add issues with ex_rs1 = ex_rs2 = 2.
- No false stall: lw x2 followed by lui x2,1 or by add x3,x0,x0 -> id_stall stays 0.
- Bypass: WB writes x5 = 0xDEADBEEF in the same cycle ID reads x5 -> ex_rs1_data = 0xDEADBEEF with BYPASS = 1, and the old value with BYPASS = 0. A WB write to x0 leaves reads of x0 at 0.
- Flush during hazard: flush = 1 while hazard = 1 -> id_stall = 0, ID/EX holds a bubble, no stale control bits.
- ex_hold = 1 for 3 cycles -> ex_* stable, id_stall = 1. After release the next instruction loads; NREG = 16 build passes the same sequence.
